mem: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, sitting between the EX/MEM pipeline register and `mem_wb`. Non-memory instructions pass through combinationally. Loads and stores run a handshaked access on the data bus and hold the pipeline with `stallreq` until the access finishes. Load data is byte-lane extracted and sign- or zero-extended before it is forwarded to `mem_wb`.

---
 rtl/mem_pkg.sv | 69 ++++++
 rtl/mem_lane.sv | 58 +++++
 rtl/mem.sv | 119 +++++++++++
 tb/tb_mem.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, opcodes, state encoding and bus payload type for the MEM stage.
package mem_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 8;
  localparam int unsigned SEL_W      = REG_W / 8;

  localparam logic [ALU_OP_W-1:0] OP_LB  = 8'hE0;
  localparam logic [ALU_OP_W-1:0] OP_LBU = 8'hE4;
  localparam logic [ALU_OP_W-1:0] OP_LH  = 8'hE1;
  localparam logic [ALU_OP_W-1:0] OP_LHU = 8'hE5;
  localparam logic [ALU_OP_W-1:0] OP_LW  = 8'hE3;
  localparam logic [ALU_OP_W-1:0] OP_SB  = 8'hE8;
  localparam logic [ALU_OP_W-1:0] OP_SH  = 8'hE9;
  localparam logic [ALU_OP_W-1:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'b00,
    MEM_ACCESS = 2'b01,
    MEM_DONE   = 2'b10
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    logic      sign;
    mem_size_e size;
  } mem_op_t;

  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] addr;
    logic [SEL_W-1:0] sel;
    logic [REG_W-1:0] wdata;
  } bus_pld_t;

  // Classify an ALU opcode into access kind, direction and extension.
  function automatic mem_op_t decode_op(input logic [ALU_OP_W-1:0] op);
    mem_op_t d;
    d.is_mem  = 1'b1;
    d.is_load = 1'b1;
    d.sign    = 1'b0;
    d.size    = SZ_NONE;
    case (op)
      OP_LB:  begin d.size = SZ_BYTE; d.sign = 1'b1; end
      OP_LBU: d.size = SZ_BYTE;
      OP_LH:  begin d.size = SZ_HALF; d.sign = 1'b1; end
      OP_LHU: d.size = SZ_HALF;
      OP_LW:  d.size = SZ_WORD;
      OP_SB:  begin d.size = SZ_BYTE; d.is_load = 1'b0; end
      OP_SH:  begin d.size = SZ_HALF; d.is_load = 1'b0; end
      OP_SW:  begin d.size = SZ_WORD; d.is_load = 1'b0; end
      default: begin
        d.is_mem  = 1'b0;
        d.is_load = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane logic: byte enables, store replication, big-endian load extraction/extension.
module mem_lane
  import mem_pkg::*;
(
  input  logic [ALU_OP_W-1:0] aluop,
  input  logic [1:0]          offset,
  input  logic [REG_W-1:0]    reg2,
  input  logic [REG_W-1:0]    rdata,
  output mem_op_t             op_c,
  output logic                misaligned_c,
  output logic [SEL_W-1:0]    sel_c,
  output logic [REG_W-1:0]    wdata_c,
  output logic [REG_W-1:0]    rdata_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant lane.
  always_comb begin
    case (offset)
      2'd0:    byte_lane = rdata[31:24];
      2'd1:    byte_lane = rdata[23:16];
      2'd2:    byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    op_c         = decode_op(aluop);
    misaligned_c = 1'b0;
    sel_c        = '0;
    wdata_c      = '0;
    rdata_c      = '0;
    case (op_c.size)
      SZ_BYTE: begin
        sel_c   = SEL_W'(4'b1000) >> offset;
        wdata_c = {4{reg2[7:0]}};
        rdata_c = {{(REG_W-8){op_c.sign & byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        misaligned_c = offset[0];
        sel_c        = SEL_W'(4'b1100) >> offset;
        wdata_c      = {2{reg2[15:0]}};
        rdata_c      = {{(REG_W-16){op_c.sign & half_lane[15]}}, half_lane};
      end
      SZ_WORD: begin
        misaligned_c = (offset != 2'd0);
        sel_c        = '1;
        wdata_c      = reg2;
        rdata_c      = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem.sv
// MEM pipeline stage: pass-through for ALU ops, handshaked bus access with stall for loads/stores.
module mem
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic                  mem_wreg_i,
  input  logic [REG_W-1:0]      mem_wdata_i,
  input  logic [ALU_OP_W-1:0]   mem_aluop_i,
  input  logic [REG_W-1:0]      mem_addr_i,
  input  logic [REG_W-1:0]      mem_reg2_i,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [REG_W-1:0]      mem_wdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [REG_W-1:0]      bus_addr,
  output logic [SEL_W-1:0]      bus_sel,
  output logic [REG_W-1:0]      bus_wdata,
  input  logic [REG_W-1:0]      bus_rdata,
  input  logic                  bus_ack,
  output logic                  stallreq,
  output logic                  misalign
);

  mem_state_e       state;
  mem_state_e       state_next;
  mem_op_t          op;
  logic             misaligned;
  logic             start;
  logic [SEL_W-1:0] sel;
  logic [REG_W-1:0] wdata_rep;
  logic [REG_W-1:0] rdata_ext;
  bus_pld_t         bus_q;
  logic             req_q;
  logic [REG_W-1:0] data_q;

  mem_lane u_lane (
    .aluop        (mem_aluop_i),
    .offset       (mem_addr_i[1:0]),
    .reg2         (mem_reg2_i),
    .rdata        (bus_rdata),
    .op_c         (op),
    .misaligned_c (misaligned),
    .sel_c        (sel),
    .wdata_c      (wdata_rep),
    .rdata_c      (rdata_ext)
  );

  assign start = op.is_mem & ~misaligned;

  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MEM_IDLE:   if (start) state_next = MEM_ACCESS;
      MEM_ACCESS: if (bus_ack) state_next = MEM_DONE;
      MEM_DONE:   state_next = MEM_IDLE;
      default:    state_next = MEM_IDLE;
    endcase
  end

  // Bus fields are loaded once on entry and held stable until the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      bus_q  <= '0;
      data_q <= '0;
    end else if (state == MEM_IDLE && start) begin
      req_q       <= 1'b1;
      bus_q.we    <= ~op.is_load;
      bus_q.addr  <= {mem_addr_i[REG_W-1:2], 2'b00};
      bus_q.sel   <= sel;
      bus_q.wdata <= wdata_rep;
    end else if (state == MEM_ACCESS && bus_ack) begin
      req_q  <= 1'b0;
      data_q <= rdata_ext;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = bus_q.we;
  assign bus_addr  = bus_q.addr;
  assign bus_sel   = bus_q.sel;
  assign bus_wdata = bus_q.wdata;

  always_comb begin
    mem_wd    = mem_wd_i;
    mem_wreg  = mem_wreg_i;
    mem_wdata = mem_wdata_i;
    stallreq  = 1'b0;
    misalign  = 1'b0;
    if (rst) begin
      mem_wd    = '0;
      mem_wreg  = 1'b0;
      mem_wdata = '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (op.is_mem && misaligned) begin
            misalign = 1'b1;
            mem_wreg = 1'b0;
          end else if (start) begin
            stallreq = 1'b1;
          end
        end
        MEM_ACCESS: stallreq = 1'b1;
        MEM_DONE:   if (op.is_load) mem_wdata = data_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem.sv
// Directed plus randomized checks of the MEM stage against an arithmetic reference model.
module tb_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [7:0]  mem_aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_reg2_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stallreq;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] ALU_ADD = 8'h20;
  logic [7:0] op_tab [9] = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB, 8'h20};

  mem dut (
    .clk(clk), .rst(rst),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stallreq(stallreq), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, 0 for non-memory ops.
  function automatic int unsigned size_of(input logic [7:0] op);
    case (op)
      8'hE0, 8'hE4, 8'hE8: return 1;
      8'hE1, 8'hE5, 8'hE9: return 2;
      8'hE3, 8'hEB:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == 8'hE8) || (op == 8'hE9) || (op == 8'hEB);
  endfunction

  // Byte b of the word (b = 0 is the most significant) is enabled when it lies in [off, off+sz).
  function automatic logic [3:0] ref_sel(input int unsigned sz, input int unsigned off);
    logic [3:0] s;
    s = '0;
    for (int unsigned b = 0; b < 4; b++)
      if (b >= off && b < off + sz) s = s | (4'b1000 >> b);
    return s;
  endfunction

  function automatic logic [31:0] ref_store(input int unsigned sz, input logic [31:0] r2);
    if (sz == 1) return (r2 & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (r2 & 32'hFFFF) * 32'h0001_0001;
    return r2;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned off;
    longint      v;
    off = addr % 4;
    case (op)
      8'hE0, 8'hE4: begin
        v = longint'((rd >> ((3 - off) * 8)) & 32'hFF);
        if (op == 8'hE0 && v >= 128) v = v - 256;
      end
      8'hE1, 8'hE5: begin
        v = longint'((rd >> ((2 - off) * 8)) & 32'hFFFF);
        if (op == 8'hE1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rd);
    endcase
    return 32'(v);
  endfunction

  task automatic drive_nop();
    mem_aluop_i = ALU_ADD;
    mem_wd_i    = 5'($urandom);
    mem_wreg_i  = 1'($urandom);
    mem_wdata_i = $urandom;
    mem_addr_i  = $urandom;
    mem_reg2_i  = $urandom;
  endtask

  task automatic do_alu(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    @(negedge clk);
    mem_aluop_i = ALU_ADD;
    mem_wd_i    = wd;
    mem_wreg_i  = wreg;
    mem_wdata_i = wdata;
    mem_addr_i  = $urandom;
    mem_reg2_i  = $urandom;
    bus_ack     = 1'($urandom);
    bus_rdata   = $urandom;
    #1;
    chk("alu_wd", 32'(mem_wd), 32'(wd));
    chk("alu_wreg", 32'(mem_wreg), 32'(wreg));
    chk("alu_wdata", mem_wdata, wdata);
    chk("alu_stall", 32'(stallreq), 0);
    chk("alu_misalign", 32'(misalign), 0);
    chk("alu_req", 32'(bus_req), 0);
  endtask

  task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rd, input int w, input logic [4:0] wd,
                        input logic wreg, input logic [31:0] wdata);
    int unsigned sz;
    int          stalls;
    logic [31:0] exp_data;
    sz     = size_of(op);
    stalls = 0;
    @(negedge clk);
    mem_aluop_i = op;
    mem_addr_i  = addr;
    mem_reg2_i  = reg2;
    mem_wd_i    = wd;
    mem_wreg_i  = wreg;
    mem_wdata_i = wdata;
    bus_ack     = 1'($urandom);
    bus_rdata   = $urandom;
    #1;
    if (addr % sz != 0) begin
      chk("mis_flag", 32'(misalign), 1);
      chk("mis_stall", 32'(stallreq), 0);
      chk("mis_wreg", 32'(mem_wreg), 0);
      chk("mis_wd", 32'(mem_wd), 32'(wd));
      chk("mis_wdata", mem_wdata, wdata);
      chk("mis_req", 32'(bus_req), 0);
      @(negedge clk);
      drive_nop();
      #1;
      chk("mis_req_after", 32'(bus_req), 0);
      chk("mis_flag_after", 32'(misalign), 0);
      return;
    end
    chk("start_misalign", 32'(misalign), 0);
    chk("start_req", 32'(bus_req), 0);
    if (stallreq) stalls++;
    for (int i = 0; i <= w; i++) begin
      @(negedge clk);
      bus_ack   = (i == w);
      bus_rdata = (i == w) ? rd : $urandom;
      #1;
      if (stallreq) stalls++;
      chk("acc_req", 32'(bus_req), 1);
      chk("acc_addr", bus_addr, addr & ~32'h3);
      chk("acc_sel", 32'(bus_sel), 32'(ref_sel(sz, addr % 4)));
      chk("acc_we", 32'(bus_we), 32'(is_store(op)));
      if (is_store(op)) chk("acc_wdata", bus_wdata, ref_store(sz, reg2));
    end
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    #1;
    if (stallreq) stalls++;
    exp_data = is_store(op) ? wdata : ref_load(op, addr, rd);
    chk("done_req", 32'(bus_req), 0);
    chk("done_wd", 32'(mem_wd), 32'(wd));
    chk("done_wreg", 32'(mem_wreg), 32'(wreg));
    chk("done_wdata", mem_wdata, exp_data);
    chk("stall_cycles", 32'(stalls), 32'(2 + w));
  endtask

  initial begin
    rst         = 1'b1;
    bus_ack     = 1'b0;
    bus_rdata   = 32'h0;
    mem_aluop_i = 8'hE3;
    mem_addr_i  = 32'h0000_0040;
    mem_reg2_i  = 32'h1234_5678;
    mem_wd_i    = 5'd9;
    mem_wreg_i  = 1'b1;
    mem_wdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_wd", 32'(mem_wd), 0);
    chk("rst_wreg", 32'(mem_wreg), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_stall", 32'(stallreq), 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_sel", 32'(bus_sel), 0);
    chk("rst_bwdata", bus_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    drive_nop();

    // Directed cases
    do_alu(5'd5, 1'b1, 32'h0000_1234);
    do_mem(8'hE0, 32'h0000_0103, 32'h0, 32'h1122_3380, 0, 5'd3, 1'b1, 32'h0000_0103);
    chk("lb_value", mem_wdata, 32'hFFFF_FF80);
    do_mem(8'hE5, 32'h0000_0102, 32'h0, 32'hAAAA_8001, 3, 5'd4, 1'b1, 32'h0000_0102);
    chk("lhu_value", mem_wdata, 32'h0000_8001);
    do_mem(8'hE8, 32'h0000_0101, 32'hDEAD_BEEF, 32'h0, 1, 5'd0, 1'b0, 32'h0000_0101);
    chk("sb_wreg_done", 32'(mem_wreg), 0);
    do_mem(8'hE3, 32'h0000_0102, 32'h0, 32'h0, 0, 5'd6, 1'b1, 32'h0000_0102);
    do_mem(8'hE1, 32'h0000_0202, 32'h0, 32'h1234_9ABC, 0, 5'd7, 1'b1, 32'h0);
    do_mem(8'hE4, 32'h0000_0300, 32'h0, 32'h8899_AABB, 2, 5'd8, 1'b1, 32'h0);

    // Reset in the middle of an access
    @(negedge clk);
    mem_aluop_i = 8'hE3;
    mem_addr_i  = 32'h0000_0200;
    mem_wd_i    = 5'd10;
    mem_wreg_i  = 1'b1;
    bus_ack     = 1'b0;
    #1;
    chk("rstacc_stall", 32'(stallreq), 1);
    @(negedge clk);
    #1;
    chk("rstacc_req", 32'(bus_req), 1);
    rst = 1'b1;
    drive_nop();
    mem_wd_i    = 5'd7;
    mem_wreg_i  = 1'b1;
    mem_wdata_i = 32'h5555_AAAA;
    #1;
    chk("rstacc_wd", 32'(mem_wd), 0);
    chk("rstacc_wreg", 32'(mem_wreg), 0);
    chk("rstacc_wdata", mem_wdata, 0);
    chk("rstacc_stall0", 32'(stallreq), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstacc_req0", 32'(bus_req), 0);
    chk("rstacc_sel0", 32'(bus_sel), 0);
    chk("rstacc_idle_wd", 32'(mem_wd), 7);
    chk("rstacc_idle_stall", 32'(stallreq), 0);
    do_mem(8'hEB, 32'h0000_0400, 32'h0BAD_CAFE, 32'h0, 1, 5'd0, 1'b0, 32'h0000_0400);

    // Randomized mix, back-to-back
    for (int n = 0; n < 60; n++) begin
      logic [7:0] op;
      op = op_tab[$urandom_range(0, 8)];
      if (op == ALU_ADD)
        do_alu(5'($urandom), 1'($urandom), $urandom);
      else
        do_mem(op, $urandom, $urandom, $urandom, $urandom_range(0, 3),
               5'($urandom), 1'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
